// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - next-address sequencer for the microprogrammed control unit
// Optional feature macro: USEQ_STACK_EN (micro-subroutine return stack, mode 111, us_push)
module microsequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                NCOND       = 4,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_W-1:0]                enc_addr,
    input  logic [ADDR_W-1:0]                cr,
    input  logic [2:0]                       n_sel,
    input  logic [$clog2(NCOND)-1:0]         cond_sel,
    input  logic                             inv,
    input  logic [NCOND-1:0]                 cond,
    input  logic                             us_push,
    input  logic                             stall,
    output logic [ADDR_W-1:0]                uaddr,
    output logic [ADDR_W-1:0]                next_uaddr,
    output logic [$clog2(STACK_DEPTH):0]     stk_depth,
    output logic                             stk_err
);

    localparam int                SD_W     = $clog2(STACK_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic              c;
    logic [ADDR_W-1:0] inc;
    logic              take_cr;
    logic              do_pop;

    assign c   = cond[cond_sel] ^ inv;
    assign inc = uaddr + ADDR_ONE;

`ifdef USEQ_STACK_EN
    localparam int               IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SD_W-1:0]  SD_ONE = SD_W'(1);
    localparam logic [SD_W-1:0]  SD_FULL = SD_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SD_W-1:0]   depth;
    logic              err;
    logic              stk_empty;
    logic              stk_full;
    logic              push_req;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;

    assign stk_empty = (depth == '0);
    assign stk_full  = (depth == SD_FULL);
    assign top_idx   = IDX_W'(depth - SD_ONE);
    assign wr_idx    = IDX_W'(depth);
    assign push_req  = us_push & take_cr;
    assign stk_depth = depth;
    assign stk_err   = err;
`else
    logic unused_nostack;

    // Without the stack, us_push has no effect; tie the stack status off.
    assign unused_nostack = us_push;
    assign stk_depth      = '0;
    assign stk_err        = 1'b0;
`endif

    // Next-address decode from the mode field and the selected condition.
    always_comb begin
        next_uaddr = RESET_ADDR;
        take_cr    = 1'b0;
        do_pop     = 1'b0;
        case (n_sel)
            3'b000: next_uaddr = enc_addr;
            3'b001: next_uaddr = RESET_ADDR;
            3'b010: begin
                next_uaddr = cr;
                take_cr    = 1'b1;
            end
            3'b011: next_uaddr = inc;
            3'b100: begin
                next_uaddr = c ? cr : enc_addr;
                take_cr    = c;
            end
            3'b101: begin
                next_uaddr = c ? cr : inc;
                take_cr    = c;
            end
            3'b110: next_uaddr = c ? inc : uaddr;
            default: begin
`ifdef USEQ_STACK_EN
                do_pop     = 1'b1;
                next_uaddr = stk_empty ? RESET_ADDR : stack_mem[top_idx];
`else
                next_uaddr = RESET_ADDR;
`endif
            end
        endcase
    end

    // Current microaddress register; stall freezes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uaddr <= RESET_ADDR;
        end else if (!stall) begin
            uaddr <= next_uaddr;
        end
    end

`ifdef USEQ_STACK_EN
    // Stack occupancy and sticky error; overflow drops the push, underflow pops nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (!stall) begin
            if (push_req) begin
                if (stk_full) begin
                    err <= 1'b1;
                end else begin
                    depth <= depth + SD_ONE;
                end
            end else if (do_pop) begin
                if (stk_empty) begin
                    err <= 1'b1;
                end else begin
                    depth <= depth - SD_ONE;
                end
            end
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!stall && push_req && !stk_full) begin
            stack_mem[wr_idx] <= inc;
        end
    end
`else
    logic unused_pop;

    // Pop requests have no target without the stack.
    assign unused_pop = do_pop ^ take_cr;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - self-checking bench for microsequencer
module tb_microsequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] enc_addr;
    logic [7:0] cr;
    logic [2:0] n_sel;
    logic [1:0] cond_sel;
    logic       inv;
    logic [3:0] cond;
    logic       us_push;
    logic       stall;
    logic [7:0] uaddr;
    logic [7:0] next_uaddr;
    logic [2:0] stk_depth;
    logic       stk_err;

    int checks;
    int failures;

    logic [7:0] m_uaddr;
    logic [7:0] m_stack[$];
    logic       m_err;

    microsequencer #(
        .ADDR_W(8), .NCOND(4), .STACK_DEPTH(4), .RESET_ADDR(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enc_addr(enc_addr), .cr(cr), .n_sel(n_sel),
        .cond_sel(cond_sel), .inv(inv), .cond(cond), .us_push(us_push),
        .stall(stall), .uaddr(uaddr), .next_uaddr(next_uaddr),
        .stk_depth(stk_depth), .stk_err(stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One microinstruction: called at posedge+1, checks the decode, then the registered result.
    task automatic step(input logic [2:0] ns, input logic [7:0] ea, input logic [7:0] ca,
                        input logic [1:0] cs, input logic iv, input logic [3:0] cd,
                        input logic push, input logic stl, input string name);
        logic       cv;
        logic [7:0] exp_next;
        logic       takes_cr;
        logic       pops;
        int         nst;
        n_sel = ns; enc_addr = ea; cr = ca; cond_sel = cs; inv = iv;
        cond = cd; us_push = push; stall = stl;
        cv = cd[cs] ^ iv;
        takes_cr = 1'b0;
        pops = 1'b0;
        case (ns)
            3'd0: exp_next = ea;
            3'd1: exp_next = 8'h00;
            3'd2: begin exp_next = ca; takes_cr = 1'b1; end
            3'd3: exp_next = 8'((int'(m_uaddr) + 1) % 256);
            3'd4: begin exp_next = cv ? ca : ea; takes_cr = cv; end
            3'd5: begin exp_next = cv ? ca : 8'((int'(m_uaddr) + 1) % 256); takes_cr = cv; end
            3'd6: exp_next = cv ? 8'((int'(m_uaddr) + 1) % 256) : m_uaddr;
            default: begin
`ifdef USEQ_STACK_EN
                pops = 1'b1;
                exp_next = (m_stack.size() > 0) ? m_stack[$] : 8'h00;
`else
                exp_next = 8'h00;
`endif
            end
        endcase
        #3;
        checks++;
        if (next_uaddr !== exp_next) begin
            failures++;
            $display("FAIL %s next_uaddr got=%h exp=%h", name, next_uaddr, exp_next);
        end
        @(posedge clk);
        #1;
        if (!stl) begin
`ifdef USEQ_STACK_EN
            if (push && takes_cr) begin
                if (m_stack.size() < 4) m_stack.push_back(8'((int'(m_uaddr) + 1) % 256));
                else m_err = 1'b1;
            end else if (pops) begin
                if (m_stack.size() > 0) void'(m_stack.pop_back());
                else m_err = 1'b1;
            end
`endif
            m_uaddr = exp_next;
        end
        nst = m_stack.size();
        checks++;
        if (uaddr !== m_uaddr) begin
            failures++;
            $display("FAIL %s uaddr got=%h exp=%h", name, uaddr, m_uaddr);
        end
        checks++;
        if (stk_depth !== 3'(nst)) begin
            failures++;
            $display("FAIL %s stk_depth got=%0d exp=%0d", name, stk_depth, nst);
        end
        checks++;
        if (stk_err !== m_err) begin
            failures++;
            $display("FAIL %s stk_err got=%b exp=%b", name, stk_err, m_err);
        end
    endtask

    task automatic go(input logic [2:0] ns, input logic [7:0] ca, input logic [1:0] cs,
                      input logic iv, input logic [3:0] cd, input logic push, input string name);
        step(ns, 8'h00, ca, cs, iv, cd, push, 1'b0, name);
    endtask

    task automatic jump_to(input logic [7:0] a);
        step(3'd0, a, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, "dispatch_setup");
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (uaddr !== 8'h00 || stk_depth !== 3'd0 || stk_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state uaddr=%h depth=%0d err=%b exp 00/0/0", uaddr, stk_depth, stk_err);
        end
        rst_n = 1'b1;
        m_uaddr = 8'h00; m_stack.delete(); m_err = 1'b0;
        jump_to(8'h2A);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uaddr !== 8'h00) begin
            failures++;
            $display("FAIL async_reset uaddr got=%h exp=00", uaddr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_uaddr = 8'h00; m_stack.delete(); m_err = 1'b0;
        for (int i = 0; i < 3; i++) go(3'd3, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, "fetch_inc");
    endtask

    task automatic test_dispatch;
        step(3'd0, 8'h05, 8'h77, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, "dispatch");
        go(3'd2, 8'h0A, 2'd0, 1'b0, 4'h0, 1'b0, "jump_cr");
        go(3'd1, 8'h33, 2'd0, 1'b0, 4'h0, 1'b0, "mode_reset");
    endtask

    task automatic test_wait;
        jump_to(8'h02);
        for (int i = 0; i < 3; i++) go(3'd6, 8'h00, 2'd0, 1'b0, 4'b1110, 1'b0, "wait_hold");
        go(3'd6, 8'h00, 2'd0, 1'b0, 4'b0001, 1'b0, "wait_done");
        for (int i = 0; i < 2; i++) go(3'd6, 8'h00, 2'd0, 1'b1, 4'b0001, 1'b0, "wait_inv_hold");
        go(3'd6, 8'h00, 2'd3, 1'b0, 4'b1000, 1'b0, "wait_sel3");
    endtask

    task automatic test_branch;
        jump_to(8'h10);
        go(3'd5, 8'h40, 2'd1, 1'b0, 4'b0010, 1'b0, "br_taken");
        jump_to(8'h10);
        go(3'd5, 8'h40, 2'd1, 1'b0, 4'b1101, 1'b0, "br_not_taken");
        step(3'd4, 8'h55, 8'h66, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0, "br4_taken");
        step(3'd4, 8'h55, 8'h66, 2'd2, 1'b1, 4'b0100, 1'b0, 1'b0, "br4_dispatch");
        jump_to(8'hFF);
        go(3'd3, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, "inc_wrap");
    endtask

    task automatic test_stack;
        jump_to(8'h20);
        go(3'd2, 8'h80, 2'd0, 1'b0, 4'h0, 1'b1, "call");
        go(3'd7, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, "return");
        go(3'd3, 8'h00, 2'd0, 1'b0, 4'h0, 1'b1, "push_ignored_inc");
        for (int i = 0; i < 5; i++)
            go(3'd5, 8'(8'h90 + 8'(i * 16)), 2'd0, 1'b0, 4'h1, 1'b1, "nested_call");
        for (int i = 0; i < 4; i++) go(3'd7, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, "nested_ret");
        go(3'd7, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, "pop_empty");
    endtask

    task automatic test_stall;
        jump_to(8'h30);
        go(3'd2, 8'h50, 2'd0, 1'b0, 4'h0, 1'b1, "stall_setup_call");
        for (int i = 0; i < 2; i++)
            step(3'd3, 8'h00, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, "stall_hold");
        step(3'd7, 8'h00, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, "stall_pop_hold");
        go(3'd3, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, "stall_release");
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            step(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 2'($urandom),
                 1'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                 "random");
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0; enc_addr = '0; cr = '0; n_sel = '0; cond_sel = '0;
        inv = 1'b0; cond = '0; us_push = 1'b0; stall = 1'b0;
        m_uaddr = 8'h00; m_err = 1'b0;
        test_reset;
        test_dispatch;
        test_wait;
        test_branch;
        test_stack;
        test_stall;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
